write_data_aligner: RTL and testbench
=====================================

# write_data_aligner

Parametrised, registered write-data front end for the configurable-aspect-ratio SRAM macro. It replicates the active element width of the incoming word across the full data bus and produces a bit-level write mask that selects one lane from the low address bits. It sits between the core-side write port and the SRAM array, with a one-entry valid/ready pipeline stage. Configuration changes are drained safely: a new aspect ratio applies only once no write of the old ratio is still in flight.

## Interface
- DATA_W, 32, data bus width; power of two, ≥2
- SEL_W, $clog2(DATA_W), lane-select width (localparam)
- CONF_W, $clog2(SEL_W+1), configuration code width (localparam); 3 for DATA_W=32
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- cfg_load  in  1  request to load cfg_conf
- cfg_conf  in  CONF_W  mode k: element width DATA_W>>k, 2^k lanes; 0 = full width, SEL_W = 1-bit
- cfg_busy  out  1  a loaded configuration is pending
- cfg_err  out  1  sticky; an illegal code (>SEL_W) was loaded
- in_valid  in  1  write request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_data  in  DATA_W  write data; only the low DATA_W>>k bits are used
- in_sel  in  SEL_W  address LSBs; only in_sel[k-1:0] are used (none for k=0)
- out_valid  out  1  output stage holds a write
- out_ready  in  1  array accepts the write
- out_din  out  DATA_W  replicated data
- out_wmask  out  DATA_W  bit write enables, 1 = write
- out_conf  out  CONF_W  mode under which this write was formed

## Operation
- Active mode register `act`; reset value 0.
- Replication: out_din = {2^k{in_data[EW-1:0]}}, where EW = DATA_W>>k.
- Mask: lane L = in_sel[k-1:0] (L = 0 when k = 0). out_wmask bits [(L+1)*EW-1 : L*EW] are 1; all other bits are 0. Mode 0 gives an all-ones mask.
- On an input fire, out_din, out_wmask and out_conf=act are captured, and out_valid is set to 1.
- On an output fire with no input fire, out_valid is cleared to 0. The data registers hold their values.
- in_ready = !reset && !cfg_busy && (!out_valid || out_ready). This allows a full-throughput back-to-back fire.
- Config load:
  - When cfg_load is high, `pend` is captured and cfg_busy is set to 1.
  - A cfg_load while busy overwrites `pend`; the last request wins.
  - An illegal code is captured as SEL_W (1-bit mode) and sets cfg_err.
- Config apply: when cfg_busy && (!out_valid || out fires this cycle), act <= pend and cfg_busy <= 0.
- No input is accepted while cfg_busy is high.
- A cfg_load and an apply in the same cycle: the load wins. cfg_busy stays 1 and the new `pend` is applied later.
- Reset values: out_valid=0, out_din=0, out_wmask=0, out_conf=0, cfg_busy=0, cfg_err=0, act=0, pend=0.
- cfg_err is cleared only by reset.
- Reset mid-operation discards any held write and any pending configuration.

## Timing
- Latency: an input fire in cycle N gives out_valid=1 in cycle N+1.
- Throughput: 1 write/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, the output registers are stable and in_ready=0.
- Config, pipeline empty: load in N, apply at the end of N+1, in_ready=1 in N+2.
- Config, pipeline full: apply occurs in the cycle the held write fires. Writes accepted before the load keep their old out_conf.
- No combinational path from in_valid to out_*.
- in_ready depends combinationally on out_ready.

## Structure
- Shared package sram_cfg_pkg holds:
  - the DATA_W default;
  - mode constants CONF_X32=0, CONF_X16=1, CONF_X8=2, CONF_X4=3, CONF_X2=4, CONF_X1=5.
- Sub-module lane_replicator: purely combinational. It maps (data, sel, mode) to (din, wmask) and is parametrised by DATA_W.
- The top level holds the output register, the config pend/act registers and the handshake logic.

## Test plan
- Reset, then mode 0: in_data=0xDEADBEEF -> next cycle out_din=0xDEADBEEF, out_wmask=0xFFFFFFFF, out_conf=0.
- Mode 2 (x8): data=0x000000A5, sel=2'b10 -> out_din=0xA5A5A5A5, out_wmask=0x00FF0000. Mode 5 (x1): data=1, sel=5'd31 -> out_din=0xFFFFFFFF, out_wmask=0x80000000.
- Stream 8 writes with out_ready held low for 3 cycles mid-stream -> no loss or duplication, order preserved, out_* stable while stalled.
- With out_valid=1 and out_ready=0, load mode 1 -> cfg_busy=1 and in_ready=0. Raise out_ready -> the held write fires with out_conf=0, and the next write carries out_conf=1.
- Load cfg_conf=7 -> cfg_err=1 and 1-bit replication takes effect. cfg_err stays set through a later legal load and is cleared only by reset.
- Assert reset while out_valid=1 and cfg_busy=1 -> next cycle all outputs are 0 and act=0.

Source files
------------

// File: rtl/sram_cfg_pkg.sv
// Shared definitions for the configurable-aspect-ratio SRAM write path.
package sram_cfg_pkg;

  localparam int SRAM_DATA_W = 32;

  // Mode k: element width SRAM_DATA_W >> k, 2^k lanes per word
  typedef enum logic [2:0] {
    CONF_X32 = 3'd0,
    CONF_X16 = 3'd1,
    CONF_X8  = 3'd2,
    CONF_X4  = 3'd3,
    CONF_X2  = 3'd4,
    CONF_X1  = 3'd5
  } conf_e;

endpackage

// File: rtl/lane_replicator.sv
// Combinational element replication and one-lane bit write mask for every mode.
module lane_replicator
  import sram_cfg_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  localparam int SEL_W = $clog2(DATA_W),
  localparam int CONF_W = $clog2(SEL_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [SEL_W-1:0]  sel,
  input  logic [CONF_W-1:0] mode,
  output logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] wmask
);

  logic [DATA_W-1:0] rep [SEL_W+1];
  logic [DATA_W-1:0] msk [SEL_W+1];

  // Every mode is built in parallel; mode only steers the final mux.
  for (genvar k = 0; k <= SEL_W; k++) begin : g_mode
    localparam int EW = DATA_W >> k;
    localparam int LANES = 1 << k;
    logic [SEL_W-1:0] lane;

    if (k == 0) begin : g_full
      assign lane = '0;
    end else begin : g_part
      assign lane = sel & SEL_W'((1 << k) - 1);
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign rep[k][l*EW +: EW] = data[EW-1:0];
      assign msk[k][l*EW +: EW] = {EW{lane == SEL_W'(l)}};
    end
  end

  always_comb begin
    din   = rep[mode];
    wmask = msk[mode];
  end

endmodule

// File: rtl/write_data_aligner.sv
// Registered write-data front end: replicates the active element, builds the lane
// mask, and holds aspect-ratio changes until no write of the old ratio is in flight.
module write_data_aligner
  import sram_cfg_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  localparam int SEL_W = $clog2(DATA_W),
  localparam int CONF_W = $clog2(SEL_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [CONF_W-1:0] cfg_conf,
  output logic              cfg_busy,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_din,
  output logic [DATA_W-1:0] out_wmask,
  output logic [CONF_W-1:0] out_conf
);

  function automatic logic [CONF_W-1:0] conf_clamp(input logic [CONF_W-1:0] c);
    if (int'(c) > SEL_W) return CONF_W'(SEL_W);
    return c;
  endfunction

  logic [CONF_W-1:0] act, pend;
  logic              busy, err;
  logic              vld_p1;
  logic [DATA_W-1:0] din_p0, wmask_p0, din_p1, wmask_p1;
  logic [CONF_W-1:0] conf_p1;
  logic              in_fire, out_fire;

  // Stage p0: combinational formatting under the active mode
  lane_replicator #(.DATA_W(DATA_W)) u_rep (
    .data  (in_data),
    .sel   (in_sel),
    .mode  (act),
    .din   (din_p0),
    .wmask (wmask_p0)
  );

  assign in_ready = !reset && !busy && (!vld_p1 || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_p1 && out_ready;

  // Stage p1: output register and configuration state
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      din_p1   <= '0;
      wmask_p1 <= '0;
      conf_p1  <= '0;
      act      <= '0;
      pend     <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (in_fire) begin
        vld_p1   <= 1'b1;
        din_p1   <= din_p0;
        wmask_p1 <= wmask_p0;
        conf_p1  <= act;
      end else if (out_fire) begin
        vld_p1 <= 1'b0;
      end

      // A fresh load outranks a same-cycle apply of the previous pending code.
      if (cfg_load) begin
        pend <= conf_clamp(cfg_conf);
        busy <= 1'b1;
        if (int'(cfg_conf) > SEL_W) err <= 1'b1;
      end else if (busy && (!vld_p1 || out_fire)) begin
        act  <= pend;
        busy <= 1'b0;
      end
    end
  end

  assign cfg_busy  = busy;
  assign cfg_err   = err;
  assign out_valid = vld_p1;
  assign out_din   = din_p1;
  assign out_wmask = wmask_p1;
  assign out_conf  = conf_p1;

endmodule

// File: tb/tb_write_data_aligner.sv
// Directed and randomized bench for write_data_aligner with a queue-based reference model.
module tb_write_data_aligner;
  import sram_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [2:0]  cfg_conf;
  logic        cfg_busy, cfg_err;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_sel;
  logic        out_valid, out_ready;
  logic [31:0] out_din, out_wmask;
  logic [2:0]  out_conf;

  int passed = 0;
  int total  = 0;

  write_data_aligner #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_conf(cfg_conf),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_din(out_din), .out_wmask(out_wmask), .out_conf(out_conf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [31:0] mask;
    logic [2:0]  conf;
  } wr_t;

  function automatic logic [31:0] ref_din(input logic [31:0] d, input int k);
    int ew = 32 >> k;
    logic [63:0] e = {32'd0, d} & ((64'd1 << ew) - 64'd1);
    logic [63:0] r = '0;
    for (int l = 0; l < (1 << k); l++) r |= e << (l * ew);
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_mask(input logic [4:0] s, input int k);
    int ew = 32 >> k;
    int ln = int'(s) & ((1 << k) - 1);
    logic [63:0] m = ((64'd1 << ew) - 64'd1) << (ln * ew);
    return m[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write through an empty pipeline with out_ready held high
  task automatic do_write(input logic [31:0] d, input logic [4:0] s, input int k);
    in_valid = 1'b1; in_data = d; in_sel = s; out_ready = 1'b1;
    #1 chk("wr_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("wr_out_valid", {31'd0, out_valid}, 32'd1);
    chk("wr_din", out_din, ref_din(d, k));
    chk("wr_wmask", out_wmask, ref_mask(s, k));
    chk("wr_conf", {29'd0, out_conf}, k);
    tick();
    chk("wr_drained", {31'd0, out_valid}, 32'd0);
  endtask

  // Configuration load with an empty pipeline: busy one cycle, then applied
  task automatic do_cfg(input logic [2:0] code);
    cfg_load = 1'b1; cfg_conf = code;
    tick();
    cfg_load = 1'b0;
    chk("cfg_busy_set", {31'd0, cfg_busy}, 32'd1);
    chk("cfg_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    chk("cfg_busy_clr", {31'd0, cfg_busy}, 32'd0);
    chk("cfg_in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t q[$];
    wr_t w;
    int  k;
    int  nwr;
    logic exp_rdy, fin, fout;

    reset = 1'b1; cfg_load = 1'b0; cfg_conf = '0; in_valid = 1'b0;
    in_data = '0; in_sel = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_din", out_din, 32'd0);
    chk("rst_out_wmask", out_wmask, 32'd0);
    chk("rst_out_conf", {29'd0, out_conf}, 32'd0);
    chk("rst_cfg_busy", {31'd0, cfg_busy}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;

    do_write(32'hDEADBEEF, 5'd7, 0);
    do_cfg(CONF_X8);
    do_write(32'h000000A5, 5'b00010, 2);
    chk("x8_din_const", out_din, 32'hA5A5A5A5);
    chk("x8_mask_const", out_wmask, 32'h00FF0000);
    do_cfg(CONF_X1);
    do_write(32'h00000001, 5'd31, 5);
    chk("x1_mask_const", out_wmask, 32'h80000000);

    // Randomized stream with a forced 3-cycle stall mid-stream
    k = $urandom_range(1, 5);
    do_cfg(3'(k));
    nwr = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_sel    = 5'($urandom);
      out_ready = (c >= 8 && c < 11) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (q.size() == 0) || out_ready;
      chk("st_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("st_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("st_din", out_din, q[0].din);
        chk("st_wmask", out_wmask, q[0].mask);
        chk("st_conf", {29'd0, out_conf}, {29'd0, q[0].conf});
      end
      fout = (q.size() != 0) && out_ready;
      fin  = in_valid && exp_rdy;
      if (fout) void'(q.pop_front());
      if (fin) begin
        w.din = ref_din(in_data, k); w.mask = ref_mask(in_sel, k); w.conf = 3'(k);
        q.push_back(w);
        nwr++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4 && q.size() != 0; c++) begin
      #1;
      chk("drain_din", out_din, q[0].din);
      void'(q.pop_front());
      tick();
    end
    chk("stream_drained", {31'd0, out_valid}, 32'd0);
    chk("stream_enough", {31'd0, nwr >= 8}, 32'd1);

    // Config change while a write is held under backpressure
    do_cfg(CONF_X32);
    in_valid = 1'b1; in_data = 32'h12345678; in_sel = '0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    cfg_load = 1'b1; cfg_conf = CONF_X16;
    tick();
    cfg_load = 1'b0;
    chk("full_busy", {31'd0, cfg_busy}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_held_conf", {29'd0, out_conf}, 32'd0);
    chk("full_held_din", out_din, 32'h12345678);
    out_ready = 1'b1;
    #1 chk("full_rdy_busy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_applied", {31'd0, cfg_busy}, 32'd0);
    chk("full_emptied", {31'd0, out_valid}, 32'd0);
    do_write(32'h0000BEEF, 5'd1, 1);
    chk("x16_mask_const", out_wmask, 32'hFFFF0000);

    // Illegal code clamps to 1-bit mode and sets the sticky error
    do_cfg(3'd7);
    chk("err_set", {31'd0, cfg_err}, 32'd1);
    do_write(32'h00000001, 5'd3, 5);
    do_cfg(CONF_X4);
    chk("err_sticky", {31'd0, cfg_err}, 32'd1);

    // Reset with a held write and a pending configuration
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_sel = 5'd2; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; cfg_load = 1'b1; cfg_conf = CONF_X2;
    tick();
    cfg_load = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_busy", {31'd0, cfg_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_din", out_din, 32'd0);
    chk("mid_rst_wmask", out_wmask, 32'd0);
    chk("mid_rst_busy", {31'd0, cfg_busy}, 32'd0);
    chk("mid_rst_err", {31'd0, cfg_err}, 32'd0);
    do_write(32'h0BADCAFE, 5'd9, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
